// File: rtl/npu_seq_pkg.sv
// rtl/npu_seq_pkg.sv - shared widths, state type and helpers for the chunk sequencer
`ifndef MEM_SIZE
`define MEM_SIZE 1024
`endif
`ifndef PREFIX_SUM_SIZE
`define PREFIX_SUM_SIZE 16
`endif

package npu_seq_pkg;

   localparam int CHUNK_CNT_W = 8;
   localparam int OUT_CNT_W   = 10;
   localparam int SPM_NUM_W   = $clog2(`MEM_SIZE / `PREFIX_SUM_SIZE);
   localparam int TOTAL_W     = CHUNK_CNT_W + OUT_CNT_W;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_WAIT_BANK = 3'd1,
      S_RUN       = 3'd2,
      S_DRAIN     = 3'd3,
      S_DONE      = 3'd4
   } seq_state_e;

   // Total chunks in a job; wide enough that the product never overflows.
   function automatic logic [TOTAL_W-1:0] job_total(input logic [CHUNK_CNT_W-1:0] chunks,
                                                    input logic [OUT_CNT_W-1:0]   outputs);
      return TOTAL_W'(chunks) * TOTAL_W'(outputs);
   endfunction

endpackage

// File: rtl/cu_chunk_sequencer_if.sv
// rtl/cu_chunk_sequencer_if.sv - descriptor, loader and compute-unit signals of the chunk sequencer
interface cu_chunk_sequencer_if;
   import npu_seq_pkg::*;

   logic                   cfg_valid_i;
   logic                   cfg_ready_o;
   logic [CHUNK_CNT_W-1:0] cfg_chunks_i;
   logic [OUT_CNT_W-1:0]   cfg_outputs_i;
   logic [SPM_NUM_W-1:0]   cfg_spm_num_i;
   logic                   ld_req_o;
   logic                   ld_bank_o;
   logic                   ld_done_i;
   logic                   rd_sel_o;
   logic                   init_o;
   logic                   chunk_start_o;
   logic [SPM_NUM_W-1:0]   rd_spm_num_o;
   logic                   chunk_end_i;
   logic                   acc_val_i;
   logic [OUT_CNT_W-1:0]   out_addr_o;
   logic                   first_chunk_o;
   logic                   busy_o;
   logic                   done_o;
   logic                   err_o;

   // Sequencer side
   modport slave (
      input  cfg_valid_i, cfg_chunks_i, cfg_outputs_i, cfg_spm_num_i,
      input  ld_done_i, chunk_end_i, acc_val_i,
      output cfg_ready_o, ld_req_o, ld_bank_o, rd_sel_o, init_o, chunk_start_o,
      output rd_spm_num_o, out_addr_o, first_chunk_o, busy_o, done_o, err_o
   );

   // Layer control / loader / compute-unit side
   modport master (
      output cfg_valid_i, cfg_chunks_i, cfg_outputs_i, cfg_spm_num_i,
      output ld_done_i, chunk_end_i, acc_val_i,
      input  cfg_ready_o, ld_req_o, ld_bank_o, rd_sel_o, init_o, chunk_start_o,
      input  rd_spm_num_o, out_addr_o, first_chunk_o, busy_o, done_o, err_o
   );

endinterface

// File: rtl/pingpong_bank_tracker.sv
// rtl/pingpong_bank_tracker.sv - ping-pong bank full flags, load/read pointers and load counter
module pingpong_bank_tracker
   import npu_seq_pkg::*;
(
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic [CHUNK_CNT_W-1:0] chunks_i,
   input  logic [OUT_CNT_W-1:0]   outputs_i,
   input  logic                   busy_i,
   input  logic                   ld_done_i,
   input  logic                   release_i,
   output logic                   ld_req_o,
   output logic                   ld_bank_o,
   output logic                   rd_sel_o,
   output logic                   rd_full_o,
   output logic                   ld_err_o
);

   logic [1:0]         full_q, full_d;
   logic               ld_bank_q, ld_bank_d;
   logic               rd_sel_q, rd_sel_d;
   logic [TOTAL_W-1:0] load_cnt_q, load_cnt_d;
   logic [TOTAL_W-1:0] total_q, total_d;
   logic               ld_take;

   // The loader may fill the bank under ld_bank only while it is empty and chunks remain.
   assign ld_req_o  = busy_i && !full_q[ld_bank_q] && (load_cnt_q < total_q);
   assign ld_take   = ld_done_i && ld_req_o;
   assign ld_err_o  = ld_done_i && !ld_req_o;
   assign ld_bank_o = ld_bank_q;
   assign rd_sel_o  = rd_sel_q;
   assign rd_full_o = full_q[rd_sel_q];

   // Next-state: a release and a load completion always address opposite banks.
   always_comb begin
      full_d     = full_q;
      ld_bank_d  = ld_bank_q;
      rd_sel_d   = rd_sel_q;
      load_cnt_d = load_cnt_q;
      total_d    = total_q;
      if (start_i) begin
         full_d     = 2'b00;
         ld_bank_d  = 1'b0;
         rd_sel_d   = 1'b0;
         load_cnt_d = '0;
         total_d    = job_total(chunks_i, outputs_i);
      end else begin
         if (release_i) begin
            full_d[rd_sel_q] = 1'b0;
            rd_sel_d         = !rd_sel_q;
         end
         if (ld_take) begin
            full_d[ld_bank_q] = 1'b1;
            ld_bank_d         = !ld_bank_q;
            load_cnt_d        = load_cnt_q + TOTAL_W'(1);
         end
      end
   end

   // Bank state registers
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         full_q     <= 2'b00;
         ld_bank_q  <= 1'b0;
         rd_sel_q   <= 1'b0;
         load_cnt_q <= '0;
         total_q    <= '0;
      end else begin
         full_q     <= full_d;
         ld_bank_q  <= ld_bank_d;
         rd_sel_q   <= rd_sel_d;
         load_cnt_q <= load_cnt_d;
         total_q    <= total_d;
      end
   end

endmodule

// File: rtl/cu_chunk_sequencer.sv
// rtl/cu_chunk_sequencer.sv - chunk-level job sequencer for one compute unit
module cu_chunk_sequencer
   import npu_seq_pkg::*;
(
   input  logic                 clk_i,
   input  logic                 rst_i,
   cu_chunk_sequencer_if.slave  bus
);

   seq_state_e             state_q;
   logic [CHUNK_CNT_W-1:0] chunks_q, chunk_idx_q;
   logic [OUT_CNT_W-1:0]   outputs_q, out_addr_q;
   logic [SPM_NUM_W-1:0]   spm_num_q;
   logic                   init_q, chunk_start_q, first_q, busy_q, done_q, err_q, err_d;
   logic                   accept, empty_job, chunk_end_ok, acc_ok;
   logic                   last_chunk, last_out, proto_err, ld_err, rd_full;

   assign accept       = (state_q == S_IDLE) && bus.cfg_valid_i;
   assign empty_job    = (bus.cfg_chunks_i == '0) || (bus.cfg_outputs_i == '0);
   assign chunk_end_ok = (state_q == S_RUN) && bus.chunk_end_i;
   // acc_val arriving with chunk_end is handled exactly as if already in DRAIN
   assign acc_ok       = (chunk_end_ok && bus.acc_val_i) ||
                         ((state_q == S_DRAIN) && bus.acc_val_i);
   assign last_chunk   = (chunk_idx_q == chunks_q - CHUNK_CNT_W'(1));
   assign last_out     = (out_addr_q == outputs_q - OUT_CNT_W'(1));

   // Protocol errors are sticky until reset or the next accepted descriptor.
   assign proto_err = ld_err ||
                      (bus.chunk_end_i && (state_q != S_RUN)) ||
                      (bus.acc_val_i && (state_q != S_RUN) && (state_q != S_DRAIN));
   assign err_d     = accept ? 1'b0 : (err_q || proto_err);

   pingpong_bank_tracker u_banks (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .start_i   (accept),
      .chunks_i  (bus.cfg_chunks_i),
      .outputs_i (bus.cfg_outputs_i),
      .busy_i    (busy_q),
      .ld_done_i (bus.ld_done_i),
      .release_i (chunk_end_ok),
      .ld_req_o  (bus.ld_req_o),
      .ld_bank_o (bus.ld_bank_o),
      .rd_sel_o  (bus.rd_sel_o),
      .rd_full_o (rd_full),
      .ld_err_o  (ld_err)
   );

   // Job FSM with chunk/output counters and registered pulse outputs
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q       <= S_IDLE;
         chunks_q      <= '0;
         outputs_q     <= '0;
         spm_num_q     <= '0;
         chunk_idx_q   <= '0;
         out_addr_q    <= '0;
         init_q        <= 1'b0;
         chunk_start_q <= 1'b0;
         first_q       <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= 1'b0;
      end else begin
         init_q        <= 1'b0;
         chunk_start_q <= 1'b0;
         done_q        <= 1'b0;
         err_q         <= err_d;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  chunks_q    <= bus.cfg_chunks_i;
                  outputs_q   <= bus.cfg_outputs_i;
                  spm_num_q   <= bus.cfg_spm_num_i;
                  chunk_idx_q <= '0;
                  out_addr_q  <= '0;
                  busy_q      <= 1'b1;
                  if (empty_job) begin
                     state_q <= S_DONE;
                     first_q <= 1'b0;
                  end else begin
                     state_q <= S_WAIT_BANK;
                     init_q  <= 1'b1;
                     first_q <= 1'b1;
                  end
               end
            end
            S_WAIT_BANK: begin
               if (rd_full) begin
                  chunk_start_q <= 1'b1;
                  state_q       <= S_RUN;
               end
            end
            S_RUN: begin
               if (chunk_end_ok) state_q <= S_DRAIN;
            end
            S_DRAIN: begin
            end
            S_DONE: begin
               // First DONE cycle raises done_o; the second returns to IDLE,
               // so cfg_ready_o follows done_o by one cycle.
               if (!done_q) begin
                  done_q <= 1'b1;
               end else begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
         // Accumulator write-back retires the chunk and may advance the output address
         if (acc_ok) begin
            if (last_chunk) begin
               chunk_idx_q <= '0;
               first_q     <= 1'b1;
               out_addr_q  <= out_addr_q + OUT_CNT_W'(1);
               state_q     <= last_out ? S_DONE : S_WAIT_BANK;
            end else begin
               chunk_idx_q <= chunk_idx_q + CHUNK_CNT_W'(1);
               first_q     <= 1'b0;
               state_q     <= S_WAIT_BANK;
            end
         end
      end
   end

   assign bus.cfg_ready_o   = (state_q == S_IDLE);
   assign bus.init_o        = init_q;
   assign bus.chunk_start_o = chunk_start_q;
   assign bus.rd_spm_num_o  = spm_num_q;
   assign bus.out_addr_o    = out_addr_q;
   assign bus.first_chunk_o = first_q;
   assign bus.busy_o        = busy_q;
   assign bus.done_o        = done_q;
   assign bus.err_o         = err_q;

endmodule

// File: tb/tb_cu_chunk_sequencer.sv
// tb/tb_cu_chunk_sequencer.sv - scoreboard testbench for cu_chunk_sequencer
module tb_cu_chunk_sequencer;
   import npu_seq_pkg::*;

   typedef struct {
      logic                 rd_sel;
      logic                 first;
      logic [OUT_CNT_W-1:0] addr;
      int                   cyc;
   } ev_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   cu_chunk_sequencer_if bus();

   cu_chunk_sequencer dut (
      .clk_i (clk),
      .rst_i (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int  n_checks = 0;
   int  n_fail   = 0;
   int  cyc      = 0;
   ev_t exp_q[$];
   ev_t obs_q[$];

   int acc_cyc, init_cyc, n_init, n_ldreq, done_cyc, last_acc, ce_first;
   int ready_at_done, ready_after, err_seen, coincide, ldreq_at_ce, ldreq_after_ce;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic push_expected(input int ch, input int outs);
      ev_t e;
      for (int k = 0; k < ch * outs; k++) begin
         e.rd_sel = logic'(k % 2);
         e.first  = ((k % ch) == 0);
         e.addr   = OUT_CNT_W'(k / ch);
         e.cyc    = 0;
         exp_q.push_back(e);
      end
   endtask

   // Drives one job: loader answers ld_req after ld_wait cycles, compute unit
   // ends a chunk c_wait cycles after chunk_start and writes back a_wait later.
   task automatic run_job(input int ch, input int outs, input int spm, input int ld_wait,
                          input int c_wait, input int a_wait, input int budget);
      int  lcnt = 0, ccnt = 0, acnt = 0;
      bit  c_pend = 0, a_pend = 0;
      ev_t o;
      obs_q.delete();
      n_init = 0; n_ldreq = 0; done_cyc = -1; last_acc = -1; ce_first = -1; init_cyc = -1;
      ready_at_done = -1; ready_after = -1; err_seen = 0; coincide = 0;
      ldreq_at_ce = -1; ldreq_after_ce = -1;
      bus.cfg_chunks_i  = CHUNK_CNT_W'(ch);
      bus.cfg_outputs_i = OUT_CNT_W'(outs);
      bus.cfg_spm_num_i = SPM_NUM_W'(spm);
      bus.cfg_valid_i   = 1'b1;
      acc_cyc = cyc;
      tick();
      bus.cfg_valid_i = 1'b0;
      for (int i = 0; i < budget && done_cyc < 0; i++) begin
         bus.ld_done_i = 1'b0; bus.chunk_end_i = 1'b0; bus.acc_val_i = 1'b0;
         if (bus.init_o) begin n_init++; init_cyc = cyc; end
         if (bus.ld_req_o) n_ldreq++;
         if (bus.err_o) err_seen = 1;
         if (ce_first >= 0 && cyc == ce_first + 1) ldreq_after_ce = int'(bus.ld_req_o);
         if (bus.done_o) begin done_cyc = cyc; ready_at_done = int'(bus.cfg_ready_o); end
         if (bus.chunk_start_o) begin
            o.rd_sel = bus.rd_sel_o; o.first = bus.first_chunk_o;
            o.addr = bus.out_addr_o; o.cyc = cyc;
            obs_q.push_back(o);
            c_pend = 1; ccnt = c_wait;
         end
         if (bus.ld_req_o) begin
            if (lcnt == 0) begin bus.ld_done_i = 1'b1; lcnt = ld_wait; end
            else lcnt--;
         end
         if (c_pend) begin
            if (ccnt == 0) begin
               bus.chunk_end_i = 1'b1; c_pend = 0; a_pend = 1; acnt = a_wait;
               if (ce_first < 0) begin ce_first = cyc; ldreq_at_ce = int'(bus.ld_req_o); end
            end else ccnt--;
         end
         if (a_pend) begin
            if (acnt == 0) begin bus.acc_val_i = 1'b1; a_pend = 0; last_acc = cyc; end
            else acnt--;
         end
         if (bus.ld_done_i && bus.chunk_end_i) coincide = 1;
         tick();
      end
      bus.ld_done_i = 1'b0; bus.chunk_end_i = 1'b0; bus.acc_val_i = 1'b0;
      ready_after = int'(bus.cfg_ready_o);
   endtask

   task automatic test_reset();
      logic [9:0] flags;
      rst_n = 1'b0;
      tick(); tick();
      flags = {bus.cfg_ready_o, bus.busy_o, bus.init_o, bus.chunk_start_o, bus.done_o,
               bus.err_o, bus.ld_req_o, bus.ld_bank_o, bus.rd_sel_o, bus.first_chunk_o};
      n_checks++;
      if (flags !== 10'b10_0000_0000) begin
         n_fail++; $display("FAIL reset_flags: got %b want 1000000000", flags);
      end
      n_checks++;
      if (bus.out_addr_o !== '0 || bus.rd_spm_num_o !== '0) begin
         n_fail++; $display("FAIL reset_busses: got addr=%0d spm=%0d want 0 0", bus.out_addr_o, bus.rd_spm_num_o);
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      ev_t e, o;
      push_expected(1, 1);
      run_job(1, 1, 5, 0, 2, 1, 200);
      n_checks++;
      if (n_init != 1 || init_cyc != acc_cyc + 1) begin
         n_fail++; $display("FAIL single_init: got n=%0d at %0d want 1 at %0d", n_init, init_cyc, acc_cyc + 1);
      end
      n_checks++;
      if (obs_q.size() == 0 || obs_q[0].cyc != acc_cyc + 3) begin
         n_fail++; $display("FAIL single_start_time: got %0d want %0d", obs_q.size() ? obs_q[0].cyc : -1, acc_cyc + 3);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++;
         if (o.rd_sel !== e.rd_sel || o.first !== e.first || o.addr !== e.addr) begin
            n_fail++; $display("FAIL single_sb: got sel=%b first=%b addr=%0d want %b %b %0d", o.rd_sel, o.first, o.addr, e.rd_sel, e.first, e.addr);
         end
      end
      n_checks++;
      if (exp_q.size() != 0 || obs_q.size() != 0) begin
         n_fail++; $display("FAIL single_sb_count: got left exp=%0d obs=%0d want 0 0", exp_q.size(), obs_q.size());
         exp_q.delete();
      end
      n_checks++;
      if (done_cyc != last_acc + 2 || ready_at_done != 0 || ready_after != 1) begin
         n_fail++; $display("FAIL single_done: got done=%0d rdy=%0d/%0d want %0d 0/1", done_cyc, ready_at_done, ready_after, last_acc + 2);
      end
      n_checks++;
      if (bus.out_addr_o !== OUT_CNT_W'(1) || bus.rd_spm_num_o !== SPM_NUM_W'(5) || err_seen != 0) begin
         n_fail++; $display("FAIL single_final: got addr=%0d spm=%0d err=%0d want 1 5 0", bus.out_addr_o, bus.rd_spm_num_o, err_seen);
      end
   endtask

   task automatic test_multi();
      ev_t e, o;
      int  prev = -1;
      push_expected(3, 2);
      run_job(3, 2, 9, 0, 1, 1, 400);
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++;
         if (o.rd_sel !== e.rd_sel || o.first !== e.first || o.addr !== e.addr) begin
            n_fail++; $display("FAIL multi_sb: got sel=%b first=%b addr=%0d want %b %b %0d", o.rd_sel, o.first, o.addr, e.rd_sel, e.first, e.addr);
         end
         n_checks++;
         if (prev >= 0 && o.cyc - prev != 4) begin
            n_fail++; $display("FAIL multi_gap: got %0d want 4", o.cyc - prev);
         end
         prev = o.cyc;
      end
      n_checks++;
      if (exp_q.size() != 0 || obs_q.size() != 0) begin
         n_fail++; $display("FAIL multi_sb_count: got left exp=%0d obs=%0d want 0 0", exp_q.size(), obs_q.size());
         exp_q.delete();
      end
      n_checks++;
      if (bus.out_addr_o !== OUT_CNT_W'(2) || err_seen != 0 || done_cyc != last_acc + 2) begin
         n_fail++; $display("FAIL multi_final: got addr=%0d err=%0d done=%0d want 2 0 %0d", bus.out_addr_o, err_seen, done_cyc, last_acc + 2);
      end
   endtask

   task automatic test_back_to_back();
      ev_t e, o;
      int  prev = -1;
      push_expected(2, 2);
      run_job(2, 2, 1, 0, 1, 0, 400);
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++;
         if (o.rd_sel !== e.rd_sel || o.first !== e.first || o.addr !== e.addr) begin
            n_fail++; $display("FAIL b2b_sb: got sel=%b first=%b addr=%0d want %b %b %0d", o.rd_sel, o.first, o.addr, e.rd_sel, e.first, e.addr);
         end
         n_checks++;
         if (prev >= 0 && o.cyc - prev != 3) begin
            n_fail++; $display("FAIL b2b_gap: got %0d want 3", o.cyc - prev);
         end
         prev = o.cyc;
      end
      n_checks++;
      if (exp_q.size() != 0 || obs_q.size() != 0 || err_seen != 0) begin
         n_fail++; $display("FAIL b2b_count: got exp=%0d obs=%0d err=%0d want 0 0 0", exp_q.size(), obs_q.size(), err_seen);
         exp_q.delete();
      end
   endtask

   task automatic test_slow_compute();
      ev_t e, o;
      push_expected(1, 3);
      run_job(1, 3, 2, 0, 10, 1, 400);
      n_checks++;
      if (ldreq_at_ce != 0 || ldreq_after_ce != 1) begin
         n_fail++; $display("FAIL slow_ldreq: got at_end=%0d after=%0d want 0 1", ldreq_at_ce, ldreq_after_ce);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++;
         if (o.rd_sel !== e.rd_sel || o.first !== e.first || o.addr !== e.addr) begin
            n_fail++; $display("FAIL slow_sb: got sel=%b first=%b addr=%0d want %b %b %0d", o.rd_sel, o.first, o.addr, e.rd_sel, e.first, e.addr);
         end
      end
      n_checks++;
      if (exp_q.size() != 0 || obs_q.size() != 0 || bus.out_addr_o !== OUT_CNT_W'(3)) begin
         n_fail++; $display("FAIL slow_count: got exp=%0d obs=%0d addr=%0d want 0 0 3", exp_q.size(), obs_q.size(), bus.out_addr_o);
         exp_q.delete();
      end
   endtask

   task automatic test_coincide();
      ev_t e, o;
      push_expected(2, 2);
      run_job(2, 2, 4, 3, 2, 1, 400);
      n_checks++;
      if (coincide != 1) begin
         n_fail++; $display("FAIL coincide_seen: got %0d want 1", coincide);
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++;
         if (o.rd_sel !== e.rd_sel || o.first !== e.first || o.addr !== e.addr) begin
            n_fail++; $display("FAIL coincide_sb: got sel=%b first=%b addr=%0d want %b %b %0d", o.rd_sel, o.first, o.addr, e.rd_sel, e.first, e.addr);
         end
      end
      n_checks++;
      if (exp_q.size() != 0 || obs_q.size() != 0 || err_seen != 0 || bus.out_addr_o !== OUT_CNT_W'(2)) begin
         n_fail++; $display("FAIL coincide_count: got exp=%0d obs=%0d err=%0d addr=%0d want 0 0 0 2", exp_q.size(), obs_q.size(), err_seen, bus.out_addr_o);
         exp_q.delete();
      end
   endtask

   task automatic test_empty();
      run_job(0, 5, 3, 0, 1, 1, 50);
      n_checks++;
      if (n_init != 0 || n_ldreq != 0 || obs_q.size() != 0) begin
         n_fail++; $display("FAIL empty_quiet: got init=%0d ldreq=%0d starts=%0d want 0 0 0", n_init, n_ldreq, obs_q.size());
      end
      n_checks++;
      if (done_cyc != acc_cyc + 2 || ready_after != 1) begin
         n_fail++; $display("FAIL empty_done: got %0d rdy=%0d want %0d 1", done_cyc, ready_after, acc_cyc + 2);
      end
      run_job(4, 0, 3, 0, 1, 1, 50);
      n_checks++;
      if (done_cyc != acc_cyc + 2 || n_ldreq != 0 || obs_q.size() != 0) begin
         n_fail++; $display("FAIL empty_out_done: got %0d ldreq=%0d starts=%0d want %0d 0 0", done_cyc, n_ldreq, obs_q.size(), acc_cyc + 2);
      end
      obs_q.delete();
   endtask

   task automatic test_error_and_reset();
      ev_t e, o;
      logic [9:0] flags;
      bit started = 0;
      bus.cfg_chunks_i = 8'd1; bus.cfg_outputs_i = 10'd2; bus.cfg_spm_num_i = SPM_NUM_W'(3);
      bus.cfg_valid_i = 1'b1;
      tick();
      bus.cfg_valid_i = 1'b0;
      bus.chunk_end_i = 1'b1;
      tick();
      bus.chunk_end_i = 1'b0;
      n_checks++;
      if (bus.err_o !== 1'b1 || bus.busy_o !== 1'b1 || bus.chunk_start_o !== 1'b0) begin
         n_fail++; $display("FAIL err_wait_bank: got err=%b busy=%b start=%b want 1 1 0", bus.err_o, bus.busy_o, bus.chunk_start_o);
      end
      for (int i = 0; i < 20 && !started; i++) begin
         bus.ld_done_i = bus.ld_req_o;
         tick();
         if (bus.chunk_start_o) started = 1;
      end
      bus.ld_done_i = 1'b0;
      n_checks++;
      if (!started || bus.err_o !== 1'b1) begin
         n_fail++; $display("FAIL err_run_reach: got started=%0d err=%b want 1 1", started, bus.err_o);
      end
      rst_n = 1'b0;
      #1;
      flags = {bus.cfg_ready_o, bus.busy_o, bus.init_o, bus.chunk_start_o, bus.done_o,
               bus.err_o, bus.ld_req_o, bus.ld_bank_o, bus.rd_sel_o, bus.first_chunk_o};
      n_checks++;
      if (flags !== 10'b10_0000_0000 || bus.out_addr_o !== '0 || bus.rd_spm_num_o !== '0) begin
         n_fail++; $display("FAIL midrun_reset: got flags=%b addr=%0d spm=%0d want 1000000000 0 0", flags, bus.out_addr_o, bus.rd_spm_num_o);
      end
      @(posedge clk); #1; cyc++;
      rst_n = 1'b1;
      tick();
      bus.ld_done_i = 1'b1;
      tick();
      bus.ld_done_i = 1'b0;
      n_checks++;
      if (bus.err_o !== 1'b1) begin
         n_fail++; $display("FAIL err_ld_idle: got %b want 1", bus.err_o);
      end
      push_expected(2, 1);
      run_job(2, 1, 7, 1, 1, 1, 300);
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++;
         if (o.rd_sel !== e.rd_sel || o.first !== e.first || o.addr !== e.addr) begin
            n_fail++; $display("FAIL post_reset_sb: got sel=%b first=%b addr=%0d want %b %b %0d", o.rd_sel, o.first, o.addr, e.rd_sel, e.first, e.addr);
         end
      end
      n_checks++;
      if (exp_q.size() != 0 || obs_q.size() != 0 || err_seen != 0 || bus.out_addr_o !== OUT_CNT_W'(1)) begin
         n_fail++; $display("FAIL post_reset_job: got exp=%0d obs=%0d err=%0d addr=%0d want 0 0 0 1", exp_q.size(), obs_q.size(), err_seen, bus.out_addr_o);
         exp_q.delete();
      end
   endtask

   initial begin
      bus.cfg_valid_i   = 1'b0;
      bus.cfg_chunks_i  = '0;
      bus.cfg_outputs_i = '0;
      bus.cfg_spm_num_i = '0;
      bus.ld_done_i     = 1'b0;
      bus.chunk_end_i   = 1'b0;
      bus.acc_val_i     = 1'b0;
      test_reset();
      test_single();
      test_multi();
      test_back_to_back();
      test_slow_compute();
      test_coincide();
      test_empty();
      test_error_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
